// File: rtl/demux_roteador_if.sv
// Handshake bundle for demux_roteador: one producer word in, N_CANAIS channel lanes out.
interface demux_roteador_if #(
  parameter int unsigned LARGURA  = 8,
  parameter int unsigned N_CANAIS = 8,
  parameter int unsigned END_W    = $clog2(N_CANAIS),
  parameter int unsigned CONT_W   = 16
);
  logic [LARGURA-1:0]          dados;
  logic [END_W-1:0]            endereco;
  logic                        difusao;
  logic                        in_valido;
  logic                        in_pronto;
  logic [N_CANAIS*LARGURA-1:0] saida;
  logic [N_CANAIS-1:0]         saida_valido;
  logic [N_CANAIS-1:0]         saida_pronto;
  logic                        erro_end;
  logic [CONT_W-1:0]           cont_descartes;

  modport master (
    output dados, endereco, difusao, in_valido, saida_pronto,
    input  in_pronto, saida, saida_valido, erro_end, cont_descartes
  );

  modport slave (
    input  dados, endereco, difusao, in_valido, saida_pronto,
    output in_pronto, saida, saida_valido, erro_end, cont_descartes
  );
endinterface

// File: rtl/demux_roteador.sv
// Registered 1-to-N_CANAIS router: one-entry holding register per channel, broadcast,
// out-of-range drop with saturating counter, idle lanes forced to zero.
module demux_roteador #(
  parameter int unsigned LARGURA  = 8,
  parameter int unsigned N_CANAIS = 8,
  parameter int unsigned END_W    = $clog2(N_CANAIS),
  parameter int unsigned CONT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  demux_roteador_if.slave  bus
);

  logic [LARGURA-1:0]  dado [N_CANAIS];
  logic [N_CANAIS-1:0] valido;
  logic [N_CANAIS-1:0] livre;
  logic [N_CANAIS-1:0] escreve;
  logic                fora;
  logic                sel_livre;
  logic                pronto;
  logic                aceita;
  logic                descarta;
  logic                erro;
  logic [CONT_W-1:0]   cont;

  // A channel can take a word if empty or if its held word leaves on this edge.
  assign livre = ~valido | bus.saida_pronto;
  assign fora  = {1'b0, bus.endereco} >= (END_W+1)'(N_CANAIS);

  always_comb begin
    sel_livre = 1'b0;
    for (int unsigned k = 0; k < N_CANAIS; k++)
      if (bus.endereco == END_W'(k)) sel_livre = livre[k];
  end

  assign pronto   = bus.difusao ? (&livre) : (fora | sel_livre);
  assign aceita   = bus.in_valido & pronto;
  assign descarta = aceita & ~bus.difusao & fora;

  always_comb begin
    escreve = '0;
    for (int unsigned k = 0; k < N_CANAIS; k++)
      escreve[k] = aceita & (bus.difusao | (~fora & (bus.endereco == END_W'(k))));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valido <= '0;
      for (int unsigned k = 0; k < N_CANAIS; k++) dado[k] <= '0;
      erro   <= 1'b0;
      cont   <= '0;
    end else begin
      // A write wins over a drain on the same edge, keeping the lane valid.
      for (int unsigned k = 0; k < N_CANAIS; k++) begin
        if (escreve[k]) begin
          valido[k] <= 1'b1;
          dado[k]   <= bus.dados;
        end else if (valido[k] && bus.saida_pronto[k]) begin
          valido[k] <= 1'b0;
          dado[k]   <= '0;
        end
      end
      erro <= descarta;
      if (descarta && (cont != '1)) cont <= cont + 1'b1;
    end
  end

  for (genvar g = 0; g < N_CANAIS; g++) begin : g_lane
    assign bus.saida[g*LARGURA +: LARGURA] = dado[g];
  end

  assign bus.in_pronto      = pronto;
  assign bus.saida_valido   = valido;
  assign bus.erro_end       = erro;
  assign bus.cont_descartes = cont;

endmodule

// File: tb/tb_demux_roteador.sv
// Bench for demux_roteador: three configurations (8x8, 5 channels, 32-bit x 16) checked
// every cycle against a channel-level model, plus directed literal checks and a word scoreboard.
module tb_demux_roteador;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Generic stimulus per instance (0: 8x8, 1: 8-bit x 5 ch, 2: 32-bit x 16 ch)
  logic [31:0] g_dados [3];
  logic [3:0]  g_end   [3];
  logic        g_dif   [3];
  logic        g_inv   [3];
  logic [15:0] g_pr    [3];

  demux_roteador_if #(.LARGURA(8),  .N_CANAIS(8),  .END_W(3), .CONT_W(16)) b0 ();
  demux_roteador_if #(.LARGURA(8),  .N_CANAIS(5),  .END_W(3), .CONT_W(16)) b1 ();
  demux_roteador_if #(.LARGURA(32), .N_CANAIS(16), .END_W(4), .CONT_W(16)) b2 ();

  demux_roteador #(.LARGURA(8),  .N_CANAIS(8),  .END_W(3), .CONT_W(16)) d0 (.clk(clk), .rst(rst), .bus(b0));
  demux_roteador #(.LARGURA(8),  .N_CANAIS(5),  .END_W(3), .CONT_W(16)) d1 (.clk(clk), .rst(rst), .bus(b1));
  demux_roteador #(.LARGURA(32), .N_CANAIS(16), .END_W(4), .CONT_W(16)) d2 (.clk(clk), .rst(rst), .bus(b2));

  assign b0.dados = g_dados[0][7:0];
  assign b0.endereco = g_end[0][2:0];
  assign b0.difusao = g_dif[0];
  assign b0.in_valido = g_inv[0];
  assign b0.saida_pronto = g_pr[0][7:0];

  assign b1.dados = g_dados[1][7:0];
  assign b1.endereco = g_end[1][2:0];
  assign b1.difusao = g_dif[1];
  assign b1.in_valido = g_inv[1];
  assign b1.saida_pronto = g_pr[1][4:0];

  assign b2.dados = g_dados[2];
  assign b2.endereco = g_end[2];
  assign b2.difusao = g_dif[2];
  assign b2.in_valido = g_inv[2];
  assign b2.saida_pronto = g_pr[2];

  function automatic int nc(int i);
    case (i)
      0: return 8;
      1: return 5;
      default: return 16;
    endcase
  endfunction

  function automatic logic [15:0] o_sv(int i);
    case (i)
      0: return 16'(b0.saida_valido);
      1: return 16'(b1.saida_valido);
      default: return b2.saida_valido;
    endcase
  endfunction

  function automatic logic [31:0] o_lane(int i, int k);
    case (i)
      0: return 32'(b0.saida[k*8 +: 8]);
      1: return 32'(b1.saida[k*8 +: 8]);
      default: return b2.saida[k*32 +: 32];
    endcase
  endfunction

  function automatic logic o_inp(int i);
    case (i)
      0: return b0.in_pronto;
      1: return b1.in_pronto;
      default: return b2.in_pronto;
    endcase
  endfunction

  function automatic logic o_err(int i);
    case (i)
      0: return b0.erro_end;
      1: return b1.erro_end;
      default: return b2.erro_end;
    endcase
  endfunction

  function automatic logic [15:0] o_cnt(int i);
    case (i)
      0: return b0.cont_descartes;
      1: return b1.cont_descartes;
      default: return b2.cont_descartes;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp_v);
    end
  endtask

  // Model: per channel "holds a word?" and "which word", plus drop count.
  bit          mv   [3][16];
  logic [31:0] md   [3][16];
  bit          merr [3];
  int          mcnt [3];
  logic [31:0] sbq  [16][$];

  function automatic bit exp_inp(int i);
    int n = nc(i);
    if (g_dif[i]) begin
      for (int k = 0; k < n; k++)
        if (mv[i][k] && !g_pr[i][k]) return 1'b0;
      return 1'b1;
    end
    if (int'(g_end[i]) >= n) return 1'b1;
    return !mv[i][g_end[i]] || g_pr[i][g_end[i]];
  endfunction

  function automatic logic [15:0] exp_sv(int i);
    logic [15:0] r = '0;
    for (int k = 0; k < nc(i); k++) r[k] = mv[i][k];
    return r;
  endfunction

  int          m_n;
  bit          m_acc;
  logic [31:0] m_word;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        for (int k = 0; k < 16; k++) begin
          mv[i][k] = 1'b0;
          md[i][k] = '0;
        end
        merr[i] = 1'b0;
        mcnt[i] = 0;
      end
      for (int k = 0; k < 16; k++) sbq[k].delete();
    end else begin
      for (int i = 0; i < 3; i++) begin
        m_n    = nc(i);
        m_acc  = g_inv[i] && exp_inp(i);
        m_word = (i == 2) ? g_dados[i] : (g_dados[i] & 32'h0000_00FF);
        for (int k = 0; k < m_n; k++)
          if (mv[i][k] && g_pr[i][k]) begin
            mv[i][k] = 1'b0;
            md[i][k] = '0;
          end
        merr[i] = 1'b0;
        if (m_acc) begin
          if (g_dif[i]) begin
            for (int k = 0; k < m_n; k++) begin
              mv[i][k] = 1'b1;
              md[i][k] = m_word;
              if (i == 2) sbq[k].push_back(m_word);
            end
          end else if (int'(g_end[i]) >= m_n) begin
            merr[i] = 1'b1;
            if (mcnt[i] < 65535) mcnt[i] = mcnt[i] + 1;
          end else begin
            mv[i][g_end[i]] = 1'b1;
            md[i][g_end[i]] = m_word;
            if (i == 2) sbq[g_end[i]].push_back(m_word);
          end
        end
      end
    end
  end

  // Per-cycle comparison of every instance against the model, plus word scoreboard on the wide one.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("i%0d.in_pronto", i), 64'(o_inp(i)), 64'(exp_inp(i)));
        chk($sformatf("i%0d.saida_valido", i), 64'(o_sv(i)), 64'(exp_sv(i)));
        chk($sformatf("i%0d.erro_end", i), 64'(o_err(i)), 64'(merr[i]));
        chk($sformatf("i%0d.cont", i), 64'(o_cnt(i)), 64'(mcnt[i]));
        for (int k = 0; k < nc(i); k++)
          chk($sformatf("i%0d.lane%0d", i, k), 64'(o_lane(i, k)), 64'(md[i][k]));
      end
      for (int k = 0; k < 16; k++) begin
        if (o_sv(2)[k] && g_pr[2][k]) begin
          chk($sformatf("sb_present%0d", k), 64'(sbq[k].size() != 0), 64'(1));
          if (sbq[k].size() != 0)
            chk($sformatf("sb_word%0d", k), 64'(o_lane(2, k)), 64'(sbq[k].pop_front()));
        end
      end
    end
  end

  task automatic drive(input int i, input logic [31:0] d, input logic [3:0] e, input bit dif, input bit v);
    g_dados[i] = d;
    g_end[i]   = e;
    g_dif[i]   = dif;
    g_inv[i]   = v;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  bit holding;

  initial begin
    for (int i = 0; i < 3; i++) begin
      drive(i, '0, '0, 1'b0, 1'b0);
      g_pr[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    step();

    // Unicast with backpressure and same-edge drain/refill
    drive(0, 32'hA5, 4'd3, 1'b0, 1'b1);
    #1 chk("A.pronto_free", 64'(b0.in_pronto), 64'(1));
    step();
    chk("A.valid_3", 64'(b0.saida_valido), 64'h08);
    chk("A.lane3_A5", 64'(b0.saida[3*8 +: 8]), 64'hA5);
    drive(0, 32'h3C, 4'd3, 1'b0, 1'b1);
    #1 chk("A.pronto_busy", 64'(b0.in_pronto), 64'(0));
    step();
    chk("A.lane3_held", 64'(b0.saida[3*8 +: 8]), 64'hA5);
    g_pr[0] = 16'h0008;
    #1 chk("A.pronto_drain", 64'(b0.in_pronto), 64'(1));
    step();
    g_inv[0] = 1'b0;
    g_pr[0]  = '0;
    #1 chk("A.valid_3b", 64'(b0.saida_valido), 64'h08);
    chk("A.lane3_3C", 64'(b0.saida[3*8 +: 8]), 64'h3C);
    g_pr[0] = 16'h00FF;
    step();
    chk("A.drained", 64'(b0.saida_valido), 64'h00);
    chk("A.lane3_zero", 64'(b0.saida[3*8 +: 8]), 64'h00);
    g_pr[0] = '0;

    // Broadcast blocked by a full channel 6
    drive(0, 32'h77, 4'd6, 1'b0, 1'b1);
    step();
    drive(0, 32'h5A, 4'd0, 1'b1, 1'b1);
    #1 chk("B.pronto_blocked", 64'(b0.in_pronto), 64'(0));
    step();
    step();
    chk("B.still_blocked", 64'(b0.in_pronto), 64'(0));
    chk("B.only_6", 64'(b0.saida_valido), 64'h40);
    g_pr[0] = 16'h0040;
    #1 chk("B.pronto_open", 64'(b0.in_pronto), 64'(1));
    step();
    g_inv[0] = 1'b0;
    g_pr[0]  = '0;
    #1 chk("B.all_valid", 64'(b0.saida_valido), 64'hFF);
    for (int k = 0; k < 8; k++)
      chk($sformatf("B.lane%0d_5A", k), 64'(b0.saida[k*8 +: 8]), 64'h5A);
    g_pr[0] = 16'h00FF;
    step();
    chk("B.drained", 64'(b0.saida_valido), 64'h00);

    // Throughput: back-to-back to channel 0 with consumer always ready
    for (int n = 0; n < 10; n++) begin
      drive(0, 32'h10 + 32'(n), 4'd0, 1'b0, 1'b1);
      #1 chk($sformatf("D.pronto%0d", n), 64'(b0.in_pronto), 64'(1));
      step();
      chk($sformatf("D.valid%0d", n), 64'(b0.saida_valido), 64'h01);
      chk($sformatf("D.word%0d", n), 64'(b0.saida[7:0]), 64'h10 + 64'(n));
    end
    g_inv[0] = 1'b0;
    step();
    chk("D.drained", 64'(b0.saida_valido), 64'h00);
    g_pr[0] = '0;

    // Out-of-range drop on 5-channel instance, broadcast never errors
    drive(1, 32'h11, 4'd1, 1'b0, 1'b1);
    step();
    drive(1, 32'h99, 4'd6, 1'b0, 1'b1);
    #1 chk("C.pronto_oor", 64'(b1.in_pronto), 64'(1));
    step();
    g_inv[1] = 1'b0;
    #1 chk("C.err_pulse", 64'(b1.erro_end), 64'(1));
    chk("C.cnt_1", 64'(b1.cont_descartes), 64'(1));
    chk("C.valid_kept", 64'(b1.saida_valido), 64'h02);
    chk("C.lane1_kept", 64'(b1.saida[1*8 +: 8]), 64'h11);
    step();
    chk("C.err_clear", 64'(b1.erro_end), 64'(0));
    g_pr[1] = 16'h001F;
    drive(1, 32'hC3, 4'd7, 1'b1, 1'b1);
    #1 chk("C.bcast_pronto", 64'(b1.in_pronto), 64'(1));
    step();
    g_inv[1] = 1'b0;
    g_pr[1]  = '0;
    #1 chk("C.bcast_no_err", 64'(b1.erro_end), 64'(0));
    chk("C.bcast_valid", 64'(b1.saida_valido), 64'h1F);
    chk("C.bcast_cnt", 64'(b1.cont_descartes), 64'(1));
    g_pr[1] = 16'h001F;
    step();
    g_pr[1] = '0;

    // Drop counter saturation
    drive(1, 32'h00, 4'd7, 1'b0, 1'b1);
    repeat (65000) step();
    chk("C.cnt_65001", 64'(b1.cont_descartes), 64'd65001);
    repeat (5000) step();
    g_inv[1] = 1'b0;
    #1 chk("C.cnt_sat", 64'(b1.cont_descartes), 64'hFFFF);
    chk("C.sat_no_valid", 64'(b1.saida_valido), 64'h00);
    step();
    chk("C.sat_err_clear", 64'(b1.erro_end), 64'(0));
    chk("C.sat_hold", 64'(b1.cont_descartes), 64'hFFFF);

    // Wide random traffic with random backpressure
    holding = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      g_pr[2] = 16'($urandom);
      if (!holding) begin
        if ($urandom_range(9) < 7)
          drive(2, $urandom, 4'($urandom_range(15)), $urandom_range(15) == 0, 1'b1);
        else
          g_inv[2] = 1'b0;
      end
      #1 holding = g_inv[2] && !exp_inp(2);
      step();
    end
    g_inv[2] = 1'b0;
    g_pr[2]  = 16'hFFFF;
    step();
    step();
    chk("E.drained", 64'(b2.saida_valido), 64'h0);
    for (int k = 0; k < 16; k++)
      chk($sformatf("E.sb_left%0d", k), 64'(sbq[k].size()), 64'(0));
    g_pr[2] = '0;

    // Asynchronous reset with channels 2 and 5 held
    drive(0, 32'h22, 4'd2, 1'b0, 1'b1);
    step();
    drive(0, 32'h55, 4'd5, 1'b0, 1'b1);
    step();
    g_inv[0] = 1'b0;
    #1 chk("R.pre_valid", 64'(b0.saida_valido), 64'h24);
    #1 rst = 1'b1;
    #1 chk("R.valid_zero", 64'(b0.saida_valido), 64'h00);
    chk("R.lane2_zero", 64'(b0.saida[2*8 +: 8]), 64'h00);
    chk("R.lane5_zero", 64'(b0.saida[5*8 +: 8]), 64'h00);
    chk("R.cnt0_zero", 64'(b0.cont_descartes), 64'(0));
    chk("R.cnt1_zero", 64'(b1.cont_descartes), 64'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    drive(0, 32'h42, 4'd2, 1'b0, 1'b1);
    #1 chk("R.pronto_after", 64'(b0.in_pronto), 64'(1));
    step();
    g_inv[0] = 1'b0;
    #1 chk("R.valid_after", 64'(b0.saida_valido), 64'h04);
    chk("R.lane2_after", 64'(b0.saida[2*8 +: 8]), 64'h42);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/demux_roteador.md
Name: demux_roteador

Overview:
- Parametrised, registered successor to the combinational 1-to-8 demultiplexer.
- Routes one LARGURA-bit word per handshake to one of N_CANAIS output channels, selected by `endereco`.
- Each channel has a one-entry holding register with its own valid/ready handshake, so a stalled consumer blocks only its own channel.
- Adds a broadcast mode, address-range checking with a drop counter, and zeroing of idle lanes; sits between a single producer and N_CANAIS independent consumers.

Parameters:
- LARGURA, 8, data word width in bits (≥1).
- N_CANAIS, 8, number of output channels (2..64; need not be a power of two).
- END_W, $clog2(N_CANAIS), width of `endereco`.
- CONT_W, 16, width of the drop counter.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- dados  in  LARGURA  input word.
- endereco  in  END_W  destination channel index.
- difusao  in  1  when 1, the word goes to all channels; `endereco` is ignored.
- in_valido  in  1  producer has a word.
- in_pronto  out  1  block accepts a word this cycle.
- saida  out  N_CANAIS*LARGURA  channel k occupies bits [k*LARGURA +: LARGURA].
- saida_valido  out  N_CANAIS  per-channel word present.
- saida_pronto  in  N_CANAIS  per-channel consumer ready.
- erro_end  out  1  one-cycle pulse when an out-of-range word is dropped.
- cont_descartes  out  CONT_W  saturating count of dropped words.

Behaviour:
- Reset (asynchronous, active-high): all `saida` lanes = 0, `saida_valido` = 0, `erro_end` = 0, `cont_descartes` = 0. Reset mid-transfer discards all held words. There is no state other than the channel registers and the counter.
- Channel k is free when `!saida_valido[k] || saida_pronto[k]`. A channel may drain and refill in the same cycle, giving full throughput.
- `in_pronto` is combinational:
  - unicast, in range: free[`endereco`];
  - unicast, out of range (`endereco` ≥ N_CANAIS): 1;
  - difusao = 1: AND of all free[k].
- Accept = `in_valido && in_pronto`, sampled at the rising edge. `in_pronto` may depend on `dados`, `endereco` and `difusao`; the producer must hold these stable while `in_valido` = 1 and not accepted.
- Unicast accept, in range: the cycle after the edge, `saida_valido[endereco]` = 1 and that lane holds `dados`.
- Broadcast accept: the cycle after the edge, all `saida_valido` = 1 and every lane = `dados`.
- Latency is exactly one cycle from accept to output valid. There is no combinational path from `dados` to `saida`.
- Drain: on an edge with `saida_valido[k] && saida_pronto[k]` and no new write to k, `saida_valido[k]` → 0 and lane k → 0. Idle lanes always read 0.
- Drain and write to the same channel on one edge: the new word is loaded and valid stays 1.
- Held words never change while `saida_valido[k] && !saida_pronto[k]`.
- Out-of-range unicast: the word is consumed (`in_pronto` = 1) and dropped; no channel changes. `erro_end` = 1 for the cycle after the edge. `cont_descartes` increments and saturates at 2^CONT_W−1, with no wrap.
- Broadcast never raises `erro_end`.
- `in_valido` = 0: no state change except drains. `erro_end` is 0 in every cycle not following a drop.
- Channel registers are independent; there is no ordering guarantee across channels.

Test Plan:
- Reset then idle: rst=1 mid-run with channels 2 and 5 valid → immediately all `saida_valido`=0, all lanes 0, `cont_descartes`=0, `in_pronto`=1 after release.
- Unicast with default params: `dados`=8'hA5, `endereco`=3, `saida_pronto`=0 → next cycle `saida_valido`=8'b0000_1000 and lane 3 = A5. A second word to channel 3 sees `in_pronto`=0. Raising `saida_pronto[3]` accepts the second word (8'h3C) on the same edge, and lane 3 = 3C next cycle.
- Broadcast backpressure: channel 6 held full, `difusao`=1, `dados`=8'h5A → `in_pronto`=0 until channel 6 drains. Then all 8 lanes = 5A and `saida_valido`=8'hFF one cycle later.
- Out of range with N_CANAIS=5 (END_W=3): `endereco`=6 → accepted, `erro_end` pulses for 1 cycle, `cont_descartes`=1, all `saida_valido` unchanged. 70 000 drops with CONT_W=16 → `cont_descartes` saturates at 16'hFFFF.
- Throughput: `saida_pronto`=all 1, back-to-back unicast to channel 0 for 10 cycles → 10 words out in 10 consecutive cycles, in order, each one cycle after its accept.
- Wide config with LARGURA=32, N_CANAIS=16: a random traffic and backpressure scoreboard finds no lost, duplicated or altered words, and idle lanes are always 0.
